tpu_cfg_regs: RTL and testbench
===============================

Name: tpu_cfg_regs

Overview:
- APB slave configuration/status register file for the TPU.
- Sits directly upstream of the top-level TPU control state machine:
  - drives start_tpu and the per-stage enables;
  - holds the operand base addresses and stage parameters;
  - captures done_tpu for software polling.
- Software clears start_tpu here to return the controller to idle.

Parameters:
- ADDR_WIDTH, 8, APB address width (byte addresses).
- DATA_WIDTH, 32, APB data width.
- AW, 10, width of each operand base-address field.
- VERSION_ID, 32'h0001_0000, value returned by the VERSION register.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  APB write (1) / read (0)
- paddr  in  ADDR_WIDTH  APB byte address
- pwdata  in  DATA_WIDTH  APB write data
- prdata  out  DATA_WIDTH  APB read data, registered
- pready  out  1  APB ready
- pslverr  out  1  APB error, valid only while pready=1
- start_tpu  out  1  CTRL[0]
- enable_matmul  out  1  CTRL[1]
- enable_norm  out  1  CTRL[2]
- enable_pool  out  1  CTRL[3]
- enable_activation  out  1  CTRL[4]
- done_tpu  in  1  level from the control FSM
- address_mat_a  out  AW  ADDR_A[AW-1:0]
- address_mat_b  out  AW  ADDR_B[AW-1:0]
- address_mat_c  out  AW  ADDR_C[AW-1:0]
- mean  out  8  NORM[7:0]
- inv_var  out  8  NORM[15:8]
- pool_window  out  2  STAGE[1:0]
- activation_type  out  1  STAGE[8]
- irq  out  1  interrupt (only with TPU_CFG_IRQ_EN)

Behaviour:
- Reset: every output and register is 0, except the read-only VERSION register. APB FSM returns to IDLE.
- APB FSM, three states:
  - IDLE: psel=1 and penable=0 → SETUP.
  - SETUP: psel=1 and penable=1 → ACCESS. psel dropped → IDLE.
  - ACCESS: pready=1 for exactly one cycle; the write commits in this cycle; prdata/pslverr are valid. Next state is IDLE.
- Fixed latency: one wait state, so pready is high in the 2nd cycle of penable.
- prdata is 0 when not in ACCESS, and 0 on error.
- pslverr=1 in ACCESS for any of:
  - unmapped address;
  - paddr[1:0]≠0;
  - write to a read-only register.
  In each case the write is dropped.
- Register map (byte offsets):
  - 0x00 CTRL, RW, bits [4:0].
  - 0x04 STATUS:
    - bit0 done_tpu, live, RO.
    - bit1 done_sticky, W1C.
  - 0x08 ADDR_A, RW.
  - 0x0C ADDR_B, RW.
  - 0x10 ADDR_C, RW.
  - 0x14 NORM, RW, bits [15:0].
  - 0x18 STAGE, RW, bits [8] and [1:0].
  - 0x1C VERSION, RO.
  - 0x20 IRQ_EN, RW, bit0 (feature only; otherwise unmapped).
  - Unused bits read 0.
- Lock rule while start_tpu=1:
  - Writes to ADDR_*, NORM, STAGE and CTRL[4:1] are ignored, with no error.
  - CTRL[0] remains writable. Writing 0 clears start_tpu; the enables keep their old values in that same write.
- done_sticky:
  - Set on a done_tpu 0→1 edge, using a one-cycle registered copy of done_tpu.
  - Cleared by writing 1 to STATUS bit1.
  - Simultaneous set and W1C in the same cycle: set wins.
- A read returns register contents as of the ACCESS cycle. A write is visible on the outputs the cycle after ACCESS.
- Reset asserted mid-transaction: the transfer is abandoned, there is no pready response, and registers return to their reset values.

Optional Feature:
- Macro: TPU_CFG_IRQ_EN.
- Defined:
  - IRQ_EN register exists at 0x20.
  - irq = done_sticky & IRQ_EN[0], registered (one cycle after done_sticky sets).
- Undefined:
  - irq port is absent.
  - 0x20 is unmapped and returns pslverr.

Decomposition:
- Shared package tpu_cfg_pkg:
  - register offset constants;
  - CTRL bit-index constants;
  - APB FSM state encoding;
  - VERSION_ID default.
- Sub-module tpu_cfg_apb_fsm: APB handshake FSM producing wr_strobe, rd_strobe and the latched address. The register bank stays in the top module.

Test Plan:
- Write 0x08=0x155, then read 0x08 → prdata=0x155. pready is high exactly in the 2nd penable cycle; pslverr=0.
- Write CTRL=0x1F, then write ADDR_A=0x3 → address_mat_a unchanged, pslverr=0. Then write CTRL=0x00 → start_tpu=0 and enables=0x0F retained.
- Pulse done_tpu 0→1 → STATUS reads 0x3. Drop done_tpu, write STATUS=0x2 → reads 0x0. Repeat with W1C in the same cycle as the edge → bit1 stays 1.
- Read 0x24, read 0x02, write 0x1C → pslverr=1, prdata=0, no register changes.
- With TPU_CFG_IRQ_EN: IRQ_EN=1, done edge → irq=1 one cycle after done_sticky sets; W1C → irq=0.
- Assert reset during SETUP after prior writes → all outputs 0, next transaction completes normally.

Source files
------------

// File: rtl/tpu_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_cfg_pkg
// Description : Shared definitions for the TPU configuration register slice.
//               Holds the register byte offsets, CTRL/STATUS/STAGE bit
//               positions, the APB FSM state encoding, the VERSION default
//               and the offset decoder.
//               Optional macro: TPU_CFG_IRQ_EN (maps IRQ_EN at 0x20).
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_cfg_pkg;

    // Register byte offsets
    localparam logic [31:0] OFF_CTRL    = 32'h00;
    localparam logic [31:0] OFF_STATUS  = 32'h04;
    localparam logic [31:0] OFF_ADDR_A  = 32'h08;
    localparam logic [31:0] OFF_ADDR_B  = 32'h0C;
    localparam logic [31:0] OFF_ADDR_C  = 32'h10;
    localparam logic [31:0] OFF_NORM    = 32'h14;
    localparam logic [31:0] OFF_STAGE   = 32'h18;
    localparam logic [31:0] OFF_VERSION = 32'h1C;
    localparam logic [31:0] OFF_IRQ_EN  = 32'h20;

    // CTRL bit indices
    localparam int CTRL_START  = 0;
    localparam int CTRL_MATMUL = 1;
    localparam int CTRL_NORM   = 2;
    localparam int CTRL_POOL   = 3;
    localparam int CTRL_ACT    = 4;
    localparam int CTRL_BITS   = 5;

    // STATUS / STAGE bit indices
    localparam int STATUS_DONE   = 0;
    localparam int STATUS_STICKY = 1;
    localparam int STAGE_ACT     = 8;

    // APB handshake FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic [31:0] VERSION_ID_DEFAULT = 32'h0001_0000;

    typedef enum logic [3:0] {
        REG_NONE,
        REG_CTRL,
        REG_STATUS,
        REG_ADDR_A,
        REG_ADDR_B,
        REG_ADDR_C,
        REG_NORM,
        REG_STAGE,
        REG_VERSION,
        REG_IRQ_EN
    } reg_sel_e;

    // Misaligned offsets never match an entry, so they decode to REG_NONE.
    function automatic reg_sel_e decode_off(input logic [31:0] off);
        reg_sel_e sel;
        case (off)
            OFF_CTRL:    sel = REG_CTRL;
            OFF_STATUS:  sel = REG_STATUS;
            OFF_ADDR_A:  sel = REG_ADDR_A;
            OFF_ADDR_B:  sel = REG_ADDR_B;
            OFF_ADDR_C:  sel = REG_ADDR_C;
            OFF_NORM:    sel = REG_NORM;
            OFF_STAGE:   sel = REG_STAGE;
            OFF_VERSION: sel = REG_VERSION;
`ifdef TPU_CFG_IRQ_EN
            OFF_IRQ_EN:  sel = REG_IRQ_EN;
`endif
            default:     sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tpu_cfg_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : tpu_cfg_regs_if
// Description : APB bus bundle for the TPU configuration registers.
//               master : drives psel/penable/pwrite/paddr/pwdata
//               slave  : drives prdata/pready/pslverr
// Revision    : 1.0 - initial release
// ============================================================================
interface tpu_cfg_regs_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/tpu_cfg_apb_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tpu_cfg_apb_fsm
// Description : APB slave handshake, fixed single wait state.
//               IDLE -> SETUP on psel & !penable, SETUP -> ACCESS on
//               psel & penable, ACCESS (pready) -> IDLE.
// Ports       : clk, reset          - clock, sync active-high reset
//               psel_i..pwdata_i    - live APB request
//               accept_o            - SETUP->ACCESS transition this cycle
//               pready_o            - high in ACCESS
//               wr_strobe_o/rd_strobe_o - ACCESS qualified by direction
//               addr_o/wdata_o      - request latched on accept
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_cfg_apb_fsm
    import tpu_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [DATA_WIDTH-1:0] pwdata_i,
    output logic                  accept_o,
    output logic                  pready_o,
    output logic                  wr_strobe_o,
    output logic                  rd_strobe_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o
);
    logic [1:0]            state_q, state_d;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (psel_i && !penable_i) state_d = ST_SETUP;
            ST_SETUP: begin
                if (!psel_i)        state_d = ST_IDLE;
                else if (penable_i) state_d = ST_ACCESS;
            end
            ST_ACCESS: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign accept_o = (state_q == ST_SETUP) && psel_i && penable_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept_o) begin
                write_q <= pwrite_i;
                addr_q  <= paddr_i;
                wdata_q <= pwdata_i;
            end
        end
    end

    assign pready_o    = (state_q == ST_ACCESS);
    assign wr_strobe_o = pready_o & write_q;
    assign rd_strobe_o = pready_o & ~write_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
endmodule
`default_nettype wire

// File: rtl/tpu_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module      : tpu_cfg_regs
// Description : APB configuration/status register file feeding the TPU
//               control FSM (start, stage enables, operand bases, stage
//               parameters) and capturing done_tpu for polling.
// Ports       : clk, reset   - clock, sync active-high reset
//               apb          - APB slave bundle (tpu_cfg_regs_if.slave)
//               start_tpu_o, enable_*_o       - CTRL[4:0]
//               address_mat_{a,b,c}_o         - ADDR_A/B/C
//               mean_o, inv_var_o             - NORM[7:0], NORM[15:8]
//               pool_window_o, activation_type_o - STAGE[1:0], STAGE[8]
//               irq_o        - done_sticky & IRQ_EN[0], registered
//               done_tpu_i   - done level from the control FSM
// Optional    : TPU_CFG_IRQ_EN - adds IRQ_EN (0x20) and irq_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_cfg_regs
    import tpu_cfg_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    AW         = 10,
    parameter logic [DATA_WIDTH-1:0] VERSION_ID = DATA_WIDTH'(VERSION_ID_DEFAULT)
) (
    input  logic          clk,
    input  logic          reset,
    tpu_cfg_regs_if.slave apb,
    output logic          start_tpu_o,
    output logic          enable_matmul_o,
    output logic          enable_norm_o,
    output logic          enable_pool_o,
    output logic          enable_activation_o,
    output logic [AW-1:0] address_mat_a_o,
    output logic [AW-1:0] address_mat_b_o,
    output logic [AW-1:0] address_mat_c_o,
    output logic [7:0]    mean_o,
    output logic [7:0]    inv_var_o,
    output logic [1:0]    pool_window_o,
    output logic          activation_type_o,
`ifdef TPU_CFG_IRQ_EN
    output logic          irq_o,
`endif
    input  logic          done_tpu_i
);
    logic                  w_accept, w_pready, w_wr_strobe, w_rd_strobe;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;

    tpu_cfg_apb_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_apb_fsm (
        .clk         (clk),
        .reset       (reset),
        .psel_i      (apb.psel),
        .penable_i   (apb.penable),
        .pwrite_i    (apb.pwrite),
        .paddr_i     (apb.paddr),
        .pwdata_i    (apb.pwdata),
        .accept_o    (w_accept),
        .pready_o    (w_pready),
        .wr_strobe_o (w_wr_strobe),
        .rd_strobe_o (w_rd_strobe),
        .addr_o      (w_wr_addr),
        .wdata_o     (w_wr_data)
    );

    logic [CTRL_BITS-1:0]  ctrl_q, ctrl_d;
    logic [AW-1:0]         addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d;
    logic [15:0]           norm_q, norm_d;
    logic [1:0]            pool_q, pool_d;
    logic                  act_q, act_d;
    logic                  done_q;
    logic                  sticky_q, sticky_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
`ifdef TPU_CFG_IRQ_EN
    logic                  irq_en_q, irq_en_d;
    logic                  irq_q;
`endif

    reg_sel_e              w_rd_sel, w_wr_sel;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_err, w_wr_ok, w_locked, w_done_rise;
    logic                  w_unused_wdata;

    assign w_unused_wdata = ^w_wr_data[DATA_WIDTH-1:16];

    // Read data is captured on the SETUP->ACCESS edge from the live address,
    // so prdata is a register that is non-zero only during ACCESS.
    always_comb begin
        w_rd_sel  = decode_off(32'(apb.paddr));
        w_rd_data = '0;
        case (w_rd_sel)
            REG_CTRL:    w_rd_data[CTRL_BITS-1:0] = ctrl_q;
            REG_STATUS: begin
                w_rd_data[STATUS_DONE]   = done_tpu_i;
                w_rd_data[STATUS_STICKY] = sticky_q;
            end
            REG_ADDR_A:  w_rd_data[AW-1:0] = addr_a_q;
            REG_ADDR_B:  w_rd_data[AW-1:0] = addr_b_q;
            REG_ADDR_C:  w_rd_data[AW-1:0] = addr_c_q;
            REG_NORM:    w_rd_data[15:0]   = norm_q;
            REG_STAGE: begin
                w_rd_data[STAGE_ACT] = act_q;
                w_rd_data[1:0]       = pool_q;
            end
            REG_VERSION: w_rd_data = VERSION_ID;
`ifdef TPU_CFG_IRQ_EN
            REG_IRQ_EN:  w_rd_data[0] = irq_en_q;
`endif
            default: ;
        endcase
        prdata_d = (w_accept && !apb.pwrite) ? w_rd_data : '0;
    end

    // Write path works on the request latched by the FSM.
    always_comb begin
        w_wr_sel    = decode_off(32'(w_wr_addr));
        w_err       = (w_wr_sel == REG_NONE) || (w_wr_strobe && (w_wr_sel == REG_VERSION));
        w_wr_ok     = w_wr_strobe && !w_err;
        w_locked    = ctrl_q[CTRL_START];
        w_done_rise = done_tpu_i && !done_q;

        ctrl_d   = ctrl_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        addr_c_d = addr_c_q;
        norm_d   = norm_q;
        pool_d   = pool_q;
        act_d    = act_q;
        sticky_d = sticky_q;
`ifdef TPU_CFG_IRQ_EN
        irq_en_d = irq_en_q;
`endif
        if (w_wr_ok) begin
            case (w_wr_sel)
                REG_CTRL: begin
                    // While running only the start bit may change; enables hold.
                    if (w_locked) ctrl_d[CTRL_START] = w_wr_data[CTRL_START];
                    else          ctrl_d = w_wr_data[CTRL_BITS-1:0];
                end
                REG_STATUS: if (w_wr_data[STATUS_STICKY]) sticky_d = 1'b0;
                REG_ADDR_A: if (!w_locked) addr_a_d = w_wr_data[AW-1:0];
                REG_ADDR_B: if (!w_locked) addr_b_d = w_wr_data[AW-1:0];
                REG_ADDR_C: if (!w_locked) addr_c_d = w_wr_data[AW-1:0];
                REG_NORM:   if (!w_locked) norm_d   = w_wr_data[15:0];
                REG_STAGE: begin
                    if (!w_locked) begin
                        act_d  = w_wr_data[STAGE_ACT];
                        pool_d = w_wr_data[1:0];
                    end
                end
`ifdef TPU_CFG_IRQ_EN
                REG_IRQ_EN: irq_en_d = w_wr_data[0];
`endif
                default: ;
            endcase
        end
        // A new done edge takes priority over a coincident W1C.
        if (w_done_rise) sticky_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_c_q <= '0;
            norm_q   <= '0;
            pool_q   <= '0;
            act_q    <= 1'b0;
            done_q   <= 1'b0;
            sticky_q <= 1'b0;
            prdata_q <= '0;
`ifdef TPU_CFG_IRQ_EN
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
`endif
        end else begin
            ctrl_q   <= ctrl_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            addr_c_q <= addr_c_d;
            norm_q   <= norm_d;
            pool_q   <= pool_d;
            act_q    <= act_d;
            done_q   <= done_tpu_i;
            sticky_q <= sticky_d;
            prdata_q <= prdata_d;
`ifdef TPU_CFG_IRQ_EN
            irq_en_q <= irq_en_d;
            irq_q    <= sticky_q & irq_en_q;
`endif
        end
    end

    assign apb.pready  = w_pready;
    assign apb.pslverr = (w_wr_strobe || w_rd_strobe) && w_err;
    assign apb.prdata  = prdata_q;

    assign start_tpu_o         = ctrl_q[CTRL_START];
    assign enable_matmul_o     = ctrl_q[CTRL_MATMUL];
    assign enable_norm_o       = ctrl_q[CTRL_NORM];
    assign enable_pool_o       = ctrl_q[CTRL_POOL];
    assign enable_activation_o = ctrl_q[CTRL_ACT];
    assign address_mat_a_o     = addr_a_q;
    assign address_mat_b_o     = addr_b_q;
    assign address_mat_c_o     = addr_c_q;
    assign mean_o              = norm_q[7:0];
    assign inv_var_o           = norm_q[15:8];
    assign pool_window_o       = pool_q;
    assign activation_type_o   = act_q;
`ifdef TPU_CFG_IRQ_EN
    assign irq_o               = irq_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_tpu_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_tpu_cfg_regs
// Description : Directed self-checking bench for tpu_cfg_regs.
//               Honours TPU_CFG_IRQ_EN when the design is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tpu_cfg_regs;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic reset;
    logic done_tpu;
    logic start_tpu, en_mm, en_norm, en_pool, en_act;
    logic [AW-1:0] addr_a, addr_b, addr_c;
    logic [7:0] mean, inv_var;
    logic [1:0] pool_window;
    logic act_type;
`ifdef TPU_CFG_IRQ_EN
    logic irq;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tpu_cfg_regs_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) apb_if ();

    tpu_cfg_regs #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .AW         (AW),
        .VERSION_ID (32'h0001_0000)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .apb                 (apb_if),
        .start_tpu_o         (start_tpu),
        .enable_matmul_o     (en_mm),
        .enable_norm_o       (en_norm),
        .enable_pool_o       (en_pool),
        .enable_activation_o (en_act),
        .address_mat_a_o     (addr_a),
        .address_mat_b_o     (addr_b),
        .address_mat_c_o     (addr_c),
        .mean_o              (mean),
        .inv_var_o           (inv_var),
        .pool_window_o       (pool_window),
        .activation_type_o   (act_type),
`ifdef TPU_CFG_IRQ_EN
        .irq_o               (irq),
`endif
        .done_tpu_i          (done_tpu)
    );

    task automatic fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One APB transfer. rc = penable cycle in which pready was seen (0 = never),
    // ra = pready on the cycle after the transfer. raise drives done_tpu high
    // at the start of the 2nd penable cycle (the ACCESS cycle).
    task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input logic raise, output logic [31:0] rd, output logic er,
                        output int rc, output logic ra);
        rd = '0;
        er = 1'b0;
        rc = 0;
        @(posedge clk); #1;
        apb_if.psel = 1'b1; apb_if.penable = 1'b0;
        apb_if.pwrite = wr; apb_if.paddr = a; apb_if.pwdata = d;
        @(posedge clk); #1;
        apb_if.penable = 1'b1;
        for (int i = 1; i <= 4 && rc == 0; i++) begin
            if (i == 2 && raise) done_tpu = 1'b1;
            @(negedge clk);
            if (apb_if.pready) begin
                rc = i;
                rd = apb_if.prdata;
                er = apb_if.pslverr;
            end
            @(posedge clk); #1;
        end
        apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
        @(negedge clk);
        ra = apb_if.pready;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;
    logic er, ra;
    int rc;

    initial begin
        reset = 1'b1; done_tpu = 1'b0;
        apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
        apb_if.paddr = '0; apb_if.pwdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({en_act, en_pool, en_norm, en_mm, start_tpu} !== 5'h00) fail("rst_ctrl", {en_act, en_pool, en_norm, en_mm, start_tpu}, 5'h00);
        checks++; if ({addr_a, addr_b, addr_c} !== 30'h0) fail("rst_addr", {addr_a, addr_b, addr_c}, 30'h0);
        checks++; if ({inv_var, mean, act_type, pool_window} !== 19'h0) fail("rst_norm_stage", {inv_var, mean, act_type, pool_window}, 19'h0);
        checks++; if ({apb_if.pready, apb_if.pslverr, apb_if.prdata} !== 34'h0) fail("rst_apb", {apb_if.pready, apb_if.pslverr, apb_if.prdata}, 34'h0);
`ifdef TPU_CFG_IRQ_EN
        checks++; if (irq !== 1'b0) fail("rst_irq", irq, 1'b0);
`endif
        @(posedge clk); #1; reset = 1'b0;

        // Basic write / read-back and handshake timing
        xfer(1'b1, 8'h08, 32'h155, 1'b0, rd, er, rc, ra);
        checks++; if (rc !== 2) fail("wr_a_ready_cycle", rc, 2);
        checks++; if (er !== 1'b0) fail("wr_a_err", er, 1'b0);
        checks++; if (ra !== 1'b0) fail("wr_a_ready_one_cycle", ra, 1'b0);
        checks++; if (addr_a !== 10'h155) fail("addr_a_out", addr_a, 10'h155);
        xfer(1'b0, 8'h08, 32'h0, 1'b0, rd, er, rc, ra);
        checks++; if (rd !== 32'h155) fail("rd_a_data", rd, 32'h155);
        checks++; if (rc !== 2) fail("rd_a_ready_cycle", rc, 2);
        checks++; if (er !== 1'b0) fail("rd_a_err", er, 1'b0);
        xfer(1'b0, 8'h1C, 32'h0, 1'b0, rd, er, rc, ra);
        checks++; if (rd !== 32'h0001_0000) fail("rd_version", rd, 32'h0001_0000);

        // Remaining parameter registers, unused bits read zero
        xfer(1'b1, 8'h0C, 32'h2AA, 1'b0, rd, er, rc, ra);
        xfer(1'b1, 8'h10, 32'h3FF, 1'b0, rd, er, rc, ra);
        checks++; if ({addr_b, addr_c} !== {10'h2AA, 10'h3FF}) fail("addr_bc_out", {addr_b, addr_c}, {10'h2AA, 10'h3FF});
        xfer(1'b1, 8'h14, 32'hFFFF_ABCD, 1'b0, rd, er, rc, ra);
        checks++; if ({inv_var, mean} !== 16'hABCD) fail("norm_out", {inv_var, mean}, 16'hABCD);
        xfer(1'b0, 8'h14, 32'h0, 1'b0, rd, er, rc, ra);
        checks++; if (rd !== 32'h0000_ABCD) fail("rd_norm", rd, 32'h0000_ABCD);
        xfer(1'b1, 8'h18, 32'hFFFF_FFFF, 1'b0, rd, er, rc, ra);
        checks++; if ({act_type, pool_window} !== 3'b111) fail("stage_out", {act_type, pool_window}, 3'b111);
        xfer(1'b0, 8'h18, 32'h0, 1'b0, rd, er, rc, ra);
        checks++; if (rd !== 32'h0000_0103) fail("rd_stage", rd, 32'h0000_0103);

        // Lock while start_tpu=1
        xfer(1'b1, 8'h00, 32'h1F, 1'b0, rd, er, rc, ra);
        checks++; if ({en_act, en_pool, en_norm, en_mm, start_tpu} !== 5'h1F) fail("ctrl_out_1f", {en_act, en_pool, en_norm, en_mm, start_tpu}, 5'h1F);
        xfer(1'b1, 8'h08, 32'h3, 1'b0, rd, er, rc, ra);
        checks++; if (er !== 1'b0) fail("locked_wr_err", er, 1'b0);
        checks++; if (addr_a !== 10'h155) fail("locked_addr_a", addr_a, 10'h155);
        xfer(1'b1, 8'h14, 32'h0, 1'b0, rd, er, rc, ra);
        checks++; if ({inv_var, mean} !== 16'hABCD) fail("locked_norm", {inv_var, mean}, 16'hABCD);
        xfer(1'b1, 8'h00, 32'h00, 1'b0, rd, er, rc, ra);
        checks++; if (start_tpu !== 1'b0) fail("stop_start", start_tpu, 1'b0);
        checks++; if ({en_act, en_pool, en_norm, en_mm} !== 4'hF) fail("stop_enables_kept", {en_act, en_pool, en_norm, en_mm}, 4'hF);
        xfer(1'b0, 8'h00, 32'h0, 1'b0, rd, er, rc, ra);
        checks++; if (rd !== 32'h1E) fail("rd_ctrl_1e", rd, 32'h1E);
        xfer(1'b1, 8'h08, 32'h3, 1'b0, rd, er, rc, ra);
        checks++; if (addr_a !== 10'h003) fail("unlocked_addr_a", addr_a, 10'h003);

        // done_sticky capture and W1C
        @(posedge clk); #1; done_tpu = 1'b1;
        repeat (2) @(posedge clk);
        xfer(1'b0, 8'h04, 32'h0, 1'b0, rd, er, rc, ra);
        checks++; if (rd !== 32'h3) fail("status_done", rd, 32'h3);
        done_tpu = 1'b0;
        xfer(1'b0, 8'h04, 32'h0, 1'b0, rd, er, rc, ra);
        checks++; if (rd !== 32'h2) fail("status_sticky_only", rd, 32'h2);
        xfer(1'b1, 8'h04, 32'h2, 1'b0, rd, er, rc, ra);
        checks++; if (er !== 1'b0) fail("status_w1c_err", er, 1'b0);
        xfer(1'b0, 8'h04, 32'h0, 1'b0, rd, er, rc, ra);
        checks++; if (rd !== 32'h0) fail("status_cleared", rd, 32'h0);
        xfer(1'b1, 8'h04, 32'h2, 1'b1, rd, er, rc, ra);
        xfer(1'b0, 8'h04, 32'h0, 1'b0, rd, er, rc, ra);
        checks++; if (rd !== 32'h3) fail("status_set_wins", rd, 32'h3);
        done_tpu = 1'b0;
        xfer(1'b1, 8'h04, 32'h2, 1'b0, rd, er, rc, ra);
        xfer(1'b0, 8'h04, 32'h0, 1'b0, rd, er, rc, ra);
        checks++; if (rd !== 32'h0) fail("status_cleared2", rd, 32'h0);

        // Error responses
        xfer(1'b0, 8'h24, 32'h0, 1'b0, rd, er, rc, ra);
        checks++; if ({er, rd} !== {1'b1, 32'h0}) fail("unmapped_rd", {er, rd}, {1'b1, 32'h0});
        xfer(1'b0, 8'h02, 32'h0, 1'b0, rd, er, rc, ra);
        checks++; if ({er, rd} !== {1'b1, 32'h0}) fail("misaligned_rd", {er, rd}, {1'b1, 32'h0});
        xfer(1'b1, 8'h1C, 32'hDEAD, 1'b0, rd, er, rc, ra);
        checks++; if ({er, rd} !== {1'b1, 32'h0}) fail("ro_wr_err", {er, rd}, {1'b1, 32'h0});
        xfer(1'b0, 8'h1C, 32'h0, 1'b0, rd, er, rc, ra);
        checks++; if (rd !== 32'h0001_0000) fail("ro_unchanged", rd, 32'h0001_0000);
        xfer(1'b1, 8'h0E, 32'h3, 1'b0, rd, er, rc, ra);
        checks++; if (er !== 1'b1) fail("misaligned_wr_err", er, 1'b1);
        checks++; if (addr_b !== 10'h2AA) fail("misaligned_wr_drop", addr_b, 10'h2AA);
`ifdef TPU_CFG_IRQ_EN
        xfer(1'b1, 8'h20, 32'h1, 1'b0, rd, er, rc, ra);
        checks++; if (er !== 1'b0) fail("irq_en_wr_err", er, 1'b0);
        xfer(1'b0, 8'h20, 32'h0, 1'b0, rd, er, rc, ra);
        checks++; if (rd !== 32'h1) fail("irq_en_rd", rd, 32'h1);
        @(posedge clk); #1; done_tpu = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (irq !== 1'b0) fail("irq_lag", irq, 1'b0);
        @(negedge clk);
        checks++; if (irq !== 1'b1) fail("irq_set", irq, 1'b1);
        done_tpu = 1'b0;
        xfer(1'b1, 8'h04, 32'h2, 1'b0, rd, er, rc, ra);
        @(negedge clk);
        checks++; if (irq !== 1'b0) fail("irq_cleared", irq, 1'b0);
`else
        xfer(1'b1, 8'h20, 32'h1, 1'b0, rd, er, rc, ra);
        checks++; if (er !== 1'b1) fail("irq_en_absent_wr", er, 1'b1);
        xfer(1'b0, 8'h20, 32'h0, 1'b0, rd, er, rc, ra);
        checks++; if ({er, rd} !== {1'b1, 32'h0}) fail("irq_en_absent_rd", {er, rd}, {1'b1, 32'h0});
`endif

        // Reset during SETUP
        xfer(1'b1, 8'h00, 32'h1E, 1'b0, rd, er, rc, ra);
        checks++; if ({en_act, en_pool, en_norm, en_mm, start_tpu} !== 5'h1E) fail("pre_reset_ctrl", {en_act, en_pool, en_norm, en_mm, start_tpu}, 5'h1E);
        @(posedge clk); #1;
        apb_if.psel = 1'b1; apb_if.penable = 1'b0; apb_if.pwrite = 1'b1;
        apb_if.paddr = 8'h0C; apb_if.pwdata = 32'h111;
        @(posedge clk); #1;
        apb_if.penable = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
        @(negedge clk);
        checks++; if (apb_if.pready !== 1'b0) fail("mid_rst_no_ready", apb_if.pready, 1'b0);
        checks++; if ({en_act, en_pool, en_norm, en_mm, start_tpu} !== 5'h00) fail("mid_rst_ctrl", {en_act, en_pool, en_norm, en_mm, start_tpu}, 5'h00);
        checks++; if ({addr_a, addr_b, addr_c, inv_var, mean, act_type, pool_window} !== 49'h0) fail("mid_rst_regs", {addr_a, addr_b, addr_c, inv_var, mean, act_type, pool_window}, 49'h0);
        @(posedge clk); #1; reset = 1'b0;
        xfer(1'b1, 8'h08, 32'h7, 1'b0, rd, er, rc, ra);
        checks++; if ({rc[1:0], er} !== {2'd2, 1'b0}) fail("post_rst_wr", {rc[1:0], er}, {2'd2, 1'b0});
        checks++; if (addr_a !== 10'h007) fail("post_rst_addr_a", addr_a, 10'h007);
        xfer(1'b0, 8'h00, 32'h0, 1'b0, rd, er, rc, ra);
        checks++; if (rd !== 32'h0) fail("post_rst_ctrl_rd", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
